uart_rx_os: RTL and testbench

- Next-generation UART receiver replacing the single-rate parity RX.
- Adds:
  - internal oversampling baud generator with runtime divisor
  - 2-flop input synchroniser
  - 3-sample majority vote per bit
  - start-bit glitch rejection
  - none/even/odd parity, applied per byte or per word
  - 1 or 2 stop bits
  - framing and overrun detection
  - valid/ready output handshake
- Sits between the pad-side rx line and the RX FIFO / register block.

---
 rtl/uart_rx_os.sv | 147 ++++++++++++++
 tb/tb_uart_rx_os.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_os.sv
// uart_rx_os: oversampling UART receiver with majority vote, parity, framing/overrun detection and valid/ready output
module uart_rx_os #(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = 16,
  parameter int DIV_W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [DIV_W-1:0]      baud_div,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  parity_per_byte,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  valid,
  input  logic                  ready,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun,
  output logic                  busy
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_WIDTH + 1);
  localparam logic [TW-1:0] T_S0 = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1 = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_RES = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_END = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BC_MAX = BW'(DATA_WIDTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic s1, rx_s, prev;
  logic [DIV_W-1:0] divc, div_cap;
  logic [TW-1:0] tcnt;
  logic [1:0] smp;
  logic [BW-1:0] bc, bc_inc;
  logic [DATA_WIDTH-1:0] sh;
  logic par, perr_acc, ferr_acc, stop2;
  logic pen, podd, pbyte, tstop;
  logic start_det, tick, res, bend, bit_v, deliver;
  assign start_det = state == IDLE && prev && !rx_s;
  assign tick = state != IDLE && divc == div_cap;
  assign res = tick && tcnt == T_RES;
  assign bend = tick && tcnt == T_END;
  // the third vote is the live sample on the resolving tick
  assign bit_v = (smp[0] & smp[1]) | (smp[0] & rx_s) | (smp[1] & rx_s);
  assign deliver = state == STOP && res && (!tstop || stop2);
  assign bc_inc = bc + 1'b1;
  assign busy = state != IDLE;
  // two-flop synchroniser plus previous-sample register for edge detection; idle level is 1
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      s1 <= 1'b1;
      rx_s <= 1'b1;
      prev <= 1'b1;
    end else begin
      s1 <= rx_in;
      rx_s <= s1;
      prev <= rx_s;
    end
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // frame sequencing: glitch reject in START, byte/word parity slots, early exit at final stop resolution
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start_det ? START : IDLE;
      START:   state_n = (res && bit_v) ? IDLE : bend ? DATA : START;
      DATA:    state_n = !bend ? DATA :
                         (pen && pbyte && bc_inc[2:0] == 3'd0) ? PARITY :
                         bc_inc == BC_MAX ? (pen ? PARITY : STOP) : DATA;
      PARITY:  state_n = !bend ? PARITY : bc < BC_MAX ? DATA : STOP;
      STOP:    state_n = deliver ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  // baud/oversample timing, config capture, sampling, shift register and error accumulators
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      divc <= '0;
      tcnt <= '0;
      div_cap <= '0;
      pen <= 1'b0;
      podd <= 1'b0;
      pbyte <= 1'b0;
      tstop <= 1'b0;
      smp <= '0;
      bc <= '0;
      sh <= '0;
      par <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      stop2 <= 1'b0;
    end else if (start_det) begin
      divc <= '0;
      tcnt <= '0;
      div_cap <= baud_div;
      pen <= parity_en;
      podd <= parity_odd;
      pbyte <= parity_per_byte;
      tstop <= two_stop;
      bc <= '0;
      par <= 1'b0;
      perr_acc <= 1'b0;
      ferr_acc <= 1'b0;
      stop2 <= 1'b0;
    end else if (state != IDLE) begin
      divc <= tick ? '0 : divc + 1'b1;
      if (tick) tcnt <= tcnt == T_END ? '0 : tcnt + 1'b1;
      if (tick && tcnt == T_S0) smp[0] <= rx_s;
      if (tick && tcnt == T_S1) smp[1] <= rx_s;
      if (res && state == DATA) begin
        sh <= {bit_v, sh[DATA_WIDTH-1:1]};
        par <= par ^ bit_v;
      end
      if (res && state == PARITY) begin
        perr_acc <= perr_acc | (bit_v ^ par ^ podd);
        par <= 1'b0;
      end
      if (res && state == STOP && !bit_v) ferr_acc <= 1'b1;
      if (bend && state == DATA) bc <= bc_inc;
      if (bend && state == STOP) stop2 <= 1'b1;
    end
  // output holding register: load when free or consumed same cycle, else drop and flag overrun
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      data <= '0;
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else if (deliver && (!valid || ready)) begin
      data <= sh;
      parity_err <= perr_acc;
      frame_err <= ferr_acc | !bit_v;
      valid <= 1'b1;
    end else if (deliver) begin
      overrun <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end
endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed checks of the oversampling UART receiver in 8-bit and 16-bit configurations
module tb_uart_rx_os;
  logic clk = 1'b0, rst = 1'b1;
  logic rx8 = 1'b1, rx16 = 1'b1, ready8 = 1'b1, ready16 = 1'b1;
  logic [15:0] baud_div = 16'd3;
  logic pen16 = 1'b0, podd16 = 1'b0, pbyte16 = 1'b0, tstop8 = 1'b0;
  logic zero = 1'b0;
  logic [7:0] data8;
  logic [15:0] data16;
  logic valid8, perr8, ferr8, ovr8, busy8;
  logic valid16, perr16, ferr16, ovr16, busy16;
  int checks = 0, errors = 0, cyc = 0, hi8 = 0, rise8 = 0;
  int b0, t0, h0;
  logic pv8 = 1'b0, pv16 = 1'b0;
  logic [10:0] q8[$];
  logic [18:0] q16[$];

  uart_rx_os #(.DATA_WIDTH(8), .OVERSAMPLE(16), .DIV_W(16)) u8 (
    .clk(clk), .rst(rst), .rx_in(rx8), .baud_div(baud_div),
    .parity_en(zero), .parity_odd(zero), .parity_per_byte(zero), .two_stop(tstop8),
    .data(data8), .valid(valid8), .ready(ready8),
    .parity_err(perr8), .frame_err(ferr8), .overrun(ovr8), .busy(busy8)
  );

  uart_rx_os #(.DATA_WIDTH(16), .OVERSAMPLE(16), .DIV_W(16)) u16 (
    .clk(clk), .rst(rst), .rx_in(rx16), .baud_div(baud_div),
    .parity_en(pen16), .parity_odd(podd16), .parity_per_byte(pbyte16), .two_stop(zero),
    .data(data16), .valid(valid16), .ready(ready16),
    .parity_err(perr16), .frame_err(ferr16), .overrun(ovr16), .busy(busy16)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record each new word (with flags) when valid rises, and count cycles valid8 is high
  always @(negedge clk) begin
    pv8 <= valid8;
    pv16 <= valid16;
    if (valid8) hi8 <= hi8 + 1;
    if (valid8 && !pv8) begin
      q8.push_back({ovr8, ferr8, perr8, data8});
      rise8 <= cyc;
    end
    if (valid16 && !pv16) q16.push_back({ovr16, ferr16, perr16, data16});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // drive n bits LSB first, 64 clk each (baud_div=3, 16x oversample), then idle high
  task automatic send(input bit w16, input logic [39:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (w16) rx16 = bits[i];
      else rx8 = bits[i];
      repeat (64) @(negedge clk);
    end
    if (w16) rx16 = 1'b1;
    else rx8 = 1'b1;
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_valid8", 32'(valid8), 0);
    chk("rst_busy8", 32'(busy8), 0);
    chk("rst_data16", 32'(data16), 0);
    chk("rst_flags16", 32'({perr16, ferr16, ovr16, valid16}), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // 0xA5, no parity, one stop, ready=1
    b0 = q8.size();
    h0 = hi8;
    t0 = cyc;
    send(1'b0, 40'({1'b1, 8'hA5, 1'b0}), 10);
    repeat (64) @(negedge clk);
    chk("a5_count", 32'(q8.size() - b0), 1);
    chk("a5_data", 32'(q8[b0][7:0]), 32'h A5);
    chk("a5_flags", 32'(q8[b0][10:8]), 0);
    chk("a5_pulse", 32'(hi8 - h0), 1);
    chk("a5_latency", 32'(rise8 - t0), 619);
    chk("a5_valid_low", 32'(valid8), 0);

    // 16-bit per-byte even parity, byte-1 parity flipped
    pen16 = 1'b1;
    podd16 = 1'b0;
    pbyte16 = 1'b1;
    b0 = q16.size();
    send(1'b1, 40'({1'b1, 1'b1, 8'h12, 1'b0, 8'hF0, 1'b0}), 20);
    repeat (64) @(negedge clk);
    chk("pb_count", 32'(q16.size() - b0), 1);
    chk("pb_data", 32'(q16[b0][15:0]), 32'h 12F0);
    chk("pb_perr", 32'(q16[b0][16]), 1);
    chk("pb_ferr", 32'(q16[b0][17]), 0);

    // per-word even parity, correct bit
    pbyte16 = 1'b0;
    send(1'b1, 40'({1'b1, 1'b0, 16'h12F0, 1'b0}), 19);
    repeat (64) @(negedge clk);
    chk("pw_count", 32'(q16.size() - b0), 2);
    chk("pw_data", 32'(q16[b0 + 1][15:0]), 32'h 12F0);
    chk("pw_perr", 32'(q16[b0 + 1][16]), 0);

    // per-word even parity, wrong bit
    send(1'b1, 40'({1'b1, 1'b1, 16'h12F0, 1'b0}), 19);
    repeat (64) @(negedge clk);
    chk("pw_bad_perr", 32'(q16[b0 + 2][16]), 1);

    // per-word odd parity, correct bit
    podd16 = 1'b1;
    send(1'b1, 40'({1'b1, 1'b1, 16'h12F0, 1'b0}), 19);
    repeat (64) @(negedge clk);
    chk("po_count", 32'(q16.size() - b0), 4);
    chk("po_perr", 32'(q16[b0 + 3][16]), 0);

    // start glitch: low for 5 ticks (20 clk)
    b0 = q8.size();
    rx8 = 1'b0;
    repeat (20) @(negedge clk);
    rx8 = 1'b1;
    repeat (22) @(negedge clk);
    chk("gl_busy_before", 32'(busy8), 1);
    @(negedge clk);
    chk("gl_busy_after", 32'(busy8), 0);
    repeat (700) @(negedge clk);
    chk("gl_no_word", 32'(q8.size() - b0), 0);
    chk("gl_valid", 32'(valid8), 0);

    // 0x00 with one-cycle high spike on the middle sample of data bit 3, stop bit low
    b0 = q8.size();
    rx8 = 1'b0;
    repeat (292) @(negedge clk);
    rx8 = 1'b1;
    @(negedge clk);
    rx8 = 1'b0;
    repeat (347) @(negedge clk);
    rx8 = 1'b1;
    repeat (64) @(negedge clk);
    chk("sp_count", 32'(q8.size() - b0), 1);
    chk("sp_data", 32'(q8[b0][7:0]), 0);
    chk("sp_ferr", 32'(q8[b0][9]), 1);
    chk("sp_perr", 32'(q8[b0][8]), 0);
    chk("sp_ferr_cleared", 32'(ferr8), 0);

    // overrun: two words with ready low
    ready8 = 1'b0;
    b0 = q8.size();
    send(1'b0, 40'({1'b1, 8'h11, 1'b0}), 10);
    repeat (64) @(negedge clk);
    send(1'b0, 40'({1'b1, 8'h22, 1'b0}), 10);
    repeat (64) @(negedge clk);
    chk("ov_valid", 32'(valid8), 1);
    chk("ov_data", 32'(data8), 32'h 11);
    chk("ov_flag", 32'(ovr8), 1);
    chk("ov_ferr", 32'(ferr8), 0);
    chk("ov_rises", 32'(q8.size() - b0), 1);
    ready8 = 1'b1;
    @(negedge clk);
    chk("ov_consumed", 32'(valid8), 0);
    chk("ov_cleared", 32'(ovr8), 0);

    // two stop bits, back-to-back frames
    tstop8 = 1'b1;
    repeat (10) @(negedge clk);
    b0 = q8.size();
    send(1'b0, 40'({2'b11, 8'h3C, 1'b0}), 11);
    t0 = cyc;
    send(1'b0, 40'({2'b11, 8'hC3, 1'b0}), 11);
    repeat (64) @(negedge clk);
    chk("ts_count", 32'(q8.size() - b0), 2);
    chk("ts_data0", 32'(q8[b0][7:0]), 32'h 3C);
    chk("ts_data1", 32'(q8[b0 + 1][7:0]), 32'h C3);
    chk("ts_flags1", 32'(q8[b0 + 1][10:8]), 0);
    chk("ts_latency", 32'(rise8 - t0), 683);

    // hold a word, then reset in the middle of the next frame
    ready8 = 1'b0;
    send(1'b0, 40'({2'b11, 8'h5A, 1'b0}), 11);
    repeat (64) @(negedge clk);
    chk("hold_data", 32'(data8), 32'h 5A);
    chk("hold_valid", 32'(valid8), 1);
    b0 = q8.size();
    rx8 = 1'b0;
    repeat (200) @(negedge clk);
    chk("mid_busy", 32'(busy8), 1);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(valid8), 0);
    chk("mr_busy", 32'(busy8), 0);
    chk("mr_data", 32'(data8), 0);
    rx8 = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (800) @(negedge clk);
    chk("mr_no_word", 32'(q8.size() - b0), 0);
    chk("mr_idle", 32'({valid8, busy8}), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
